// File: rtl/ll_fifo_pop_arbiter.sv
// Drain stage for the shared linked-list FIFO: round-robin pop arbiter feeding a 2-entry
// valid/ready output buffer. Define LL_ARB_FIXED_PRIO_EN for lowest-index-first arbitration.
module ll_fifo_pop_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NUM_FIFOS = 2,
   parameter int unsigned SEL_WIDTH = $clog2(NUM_FIFOS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_FIFOS-1:0] empty,
   input  logic [WIDTH-1:0]     data_out,
   output logic                 pop,
   output logic [SEL_WIDTH-1:0] pop_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_WIDTH-1:0] out_sel
);

   logic [1:0]           count_q, count_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [SEL_WIDTH-1:0] sel_mem_q [2];
   logic [WIDTH-1:0]     data_mem_q [2];
   logic [SEL_WIDTH-1:0] rr_q;
   logic [SEL_WIDTH-1:0] grant;
   logic [SEL_WIDTH-1:0] grant_hi, grant_lo;
   logic                 found_hi, found_lo;
   logic                 deq;

   // Cyclic scan from rr_q: first non-empty at or above the pointer, else the lowest below it.
   always_comb begin
      grant_hi = '0;
      grant_lo = '0;
      found_hi = 1'b0;
      found_lo = 1'b0;
      for (int i = 0; i < int'(NUM_FIFOS); i++) begin
         if (!empty[i]) begin
            if (SEL_WIDTH'(i) >= rr_q) begin
               if (!found_hi) begin
                  grant_hi = SEL_WIDTH'(i);
                  found_hi = 1'b1;
               end
            end else if (!found_lo) begin
               grant_lo = SEL_WIDTH'(i);
               found_lo = 1'b1;
            end
         end
      end
      grant = found_hi ? grant_hi : grant_lo;
   end

   always_comb begin
      pop       = rst & (count_q != 2'd2) & ~(&empty);
      pop_sel   = pop ? grant : '0;
      out_valid = (count_q != 2'd0);
      deq       = out_valid & out_ready;
      out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
      out_sel   = out_valid ? sel_mem_q[rd_ptr_q] : '0;
   end

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (pop) wr_ptr_d = ~wr_ptr_q;
      if (deq) rd_ptr_d = ~rd_ptr_q;
      unique case ({pop, deq})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q    <= 2'd0;
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         sel_mem_q  <= '{default: '0};
         data_mem_q <= '{default: '0};
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         if (pop) begin
            sel_mem_q[wr_ptr_q]  <= grant;
            data_mem_q[wr_ptr_q] <= data_out;
         end
      end
   end

`ifdef LL_ARB_FIXED_PRIO_EN
   assign rr_q = '0;
`else
   localparam logic [SEL_WIDTH-1:0] LastSel = SEL_WIDTH'(NUM_FIFOS - 1);

   logic [SEL_WIDTH-1:0] rr_d;

   always_comb begin
      rr_d = rr_q;
      if (pop) rr_d = (grant == LastSel) ? '0 : grant + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rr_q <= '0;
      else      rr_q <= rr_d;
   end
`endif

endmodule
